// File: rtl/io_timer_irq_pkg.sv
// io_timer_irq_pkg: register map offsets, CTRL bit positions and shared helpers
package io_timer_irq_pkg;
  localparam logic [31:0] OFF_ID     = 32'h00;
  localparam logic [31:0] OFF_PEND   = 32'h04;
  localparam logic [31:0] OFF_MASK   = 32'h08;
  localparam logic [31:0] OFF_PRESC  = 32'h0C;
  localparam logic [31:0] OFF_USEC   = 32'h10;
  localparam logic [31:0] OFF_TMR    = 32'h20;
  localparam logic [31:0] TMR_STRIDE = 32'h10;
  localparam logic [31:0] TMR_RELOAD = 32'h0;
  localparam logic [31:0] TMR_COUNT  = 32'h4;
  localparam logic [31:0] TMR_CTRL   = 32'h8;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  function automatic int nirq(input int n_tmr, input int n_ext);
    return n_tmr + n_ext;
  endfunction
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    for (int b = 0; b < 4; b++) old[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return old;
  endfunction
endpackage

// File: rtl/io_timer_chan.sv
// io_timer_chan: one down-counting timer channel, periodic or one-shot
//  CLK/RESN clock and async active-low reset; tick prescaler strobe
//  reload_we/reload_wd RELOAD write (byte-merged); ctrl_we/ctrl_wd CTRL write {ONESHOT,EN}
//  reload/count/en/oneshot register readback; pend_set one-cycle PEND set strobe
module io_timer_chan
  import io_timer_irq_pkg::*;
(
  input  logic        CLK,
  input  logic        RESN,
  input  logic        tick,
  input  logic        reload_we,
  input  logic [31:0] reload_wd,
  input  logic        ctrl_we,
  input  logic [1:0]  ctrl_wd,
  output logic [31:0] reload,
  output logic [31:0] count,
  output logic        en,
  output logic        oneshot,
  output logic        pend_set
);
  logic [31:0] reload_q, reload_d, count_q, count_d;
  logic en_q, en_d, os_q, os_d;
  always_comb begin
    pend_set = tick & en_q & (count_q == 32'd0);
    reload_d = reload_we ? reload_wd : reload_q;
    // a RELOAD write overrides any tick in the same cycle
    count_d  = reload_we ? reload_wd :
               (tick & en_q) ? (count_q == 32'd0 ? reload_q : count_q - 32'd1) : count_q;
    en_d     = ctrl_we ? ctrl_wd[CTRL_EN] : (pend_set & os_q) ? 1'b0 : en_q;
    os_d     = ctrl_we ? ctrl_wd[CTRL_ONESHOT] : os_q;
  end
  always_ff @(posedge CLK or negedge RESN)
    if (!RESN) begin
      reload_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
      os_q     <= 1'b0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
      en_q     <= en_d;
      os_q     <= os_d;
    end
  assign reload  = reload_q;
  assign count   = count_q;
  assign en      = en_q;
  assign oneshot = os_q;
endmodule

// File: rtl/io_timer_irq.sv
// io_timer_irq: X-bus timer/interrupt controller with prescaled timers, external IRQs and usec counter
//  CLK/RESN clock and async active-low reset
//  XDREQ/XWR/XRD/XBE/XADDR/XATAI bus request, strobes, byte enables, address, write data
//  XATAO/XDACK registered read data and acknowledge
//  EIRQ async rising-edge external IRQs; XIRQ core IRQ line; IRQID lowest active source
module io_timer_irq
  import io_timer_irq_pkg::*;
#(
  parameter int NTMR  = 4,
  parameter int NEXT  = 4,
  parameter int CLKHZ = 100000000,
  parameter int RWAIT = 1,
  parameter int AW    = 8
) (
  input  logic                          CLK,
  input  logic                          RESN,
  input  logic                          XDREQ,
  input  logic                          XWR,
  input  logic                          XRD,
  input  logic [3:0]                    XBE,
  input  logic [31:0]                   XADDR,
  input  logic [31:0]                   XATAI,
  output logic [31:0]                   XATAO,
  output logic                          XDACK,
  input  logic [(NEXT>0?NEXT:1)-1:0]    EIRQ,
  output logic                          XIRQ,
  output logic [4:0]                    IRQID
);
  localparam int NIRQ      = nirq(NTMR, NEXT);
  localparam int NE        = NEXT > 0 ? NEXT : 1;
  localparam int PRESC_RST = CLKHZ / 1000 - 1;
  localparam int UDIV      = CLKHZ / 1000000 - 1;
  logic [NIRQ-1:0] pend_q, pend_d, mask_q, mask_d, irq_set, w1c;
  logic [31:0] presc_q, presc_d, pcnt_q, pcnt_d, usec_q, usec_d, udiv_q, udiv_d;
  logic [31:0] xatao_q, xatao_d, rdata, off;
  logic [1:0]  wcnt_q, wcnt_d;
  logic        rack_q, rack_d, xirq_q, xirq_d;
  logic [4:0]  irqid_q, irqid_d;
  logic [NE-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic        we, re, busy, tick;
  logic [NTMR-1:0] reload_we, ctrl_we, en_w, os_w, tmr_set;
  logic [31:0] reload_w [NTMR];
  logic [31:0] count_w [NTMR];
  logic [31:0] reload_wd [NTMR];
  logic [1:0]  ctrl_wd [NTMR];
  logic unused;
  assign unused = ^{XADDR[31:AW], XADDR[1:0]};
  always_comb begin
    off  = 32'({XADDR[AW-1:2], 2'b00});
    we   = XDREQ & XWR;
    busy = (wcnt_q != 2'd0) | rack_q;
    // a read already in its wait window is not restarted by a held XDREQ
    re   = XDREQ & XRD & ~XWR & ~busy;
    tick = pcnt_q == 32'd0;
  end
  always_comb begin
    rdata = '0;
    rdata = off == OFF_ID    ? {xirq_q, 2'b00, irqid_q, 8'(NEXT), 8'(NTMR), 8'(CLKHZ / 1000000)} : rdata;
    rdata = off == OFF_PEND  ? 32'(pend_q) : rdata;
    rdata = off == OFF_MASK  ? 32'(mask_q) : rdata;
    rdata = off == OFF_PRESC ? presc_q : rdata;
    rdata = off == OFF_USEC  ? usec_q : rdata;
    for (int n = 0; n < NTMR; n++) begin
      rdata = off == OFF_TMR + TMR_STRIDE * 32'(n) + TMR_RELOAD ? reload_w[n] : rdata;
      rdata = off == OFF_TMR + TMR_STRIDE * 32'(n) + TMR_COUNT  ? count_w[n] : rdata;
      rdata = off == OFF_TMR + TMR_STRIDE * 32'(n) + TMR_CTRL   ? {30'b0, os_w[n], en_w[n]} : rdata;
    end
  end
  always_comb begin
    irq_set = NIRQ'(tmr_set);
    for (int i = 0; i < NEXT; i++) irq_set[NTMR+i] = sync2_q[i] & ~sync3_q[i];
    w1c     = (we && off == OFF_PEND) ? NIRQ'(be_merge(32'b0, XATAI, XBE)) : '0;
    // clearing first, then OR-ing the sets, lets a same-cycle set win over W1C
    pend_d  = (pend_q & ~w1c) | irq_set;
    mask_d  = (we && off == OFF_MASK) ? NIRQ'(be_merge(32'(mask_q), XATAI, XBE)) : mask_q;
    presc_d = (we && off == OFF_PRESC) ? be_merge(presc_q, XATAI, XBE) : presc_q;
    pcnt_d  = (we && off == OFF_PRESC) ? presc_d : tick ? presc_q : pcnt_q - 32'd1;
    udiv_d  = udiv_q == 32'd0 ? 32'(UDIV) : udiv_q - 32'd1;
    usec_d  = udiv_q == 32'd0 ? usec_q + 32'd1 : usec_q;
    xatao_d = re ? rdata : xatao_q;
    wcnt_d  = re ? 2'(RWAIT) : wcnt_q != 2'd0 ? wcnt_q - 2'd1 : wcnt_q;
    rack_d  = wcnt_q == 2'd1;
    xirq_d  = |(pend_q & mask_q);
    irqid_d = '0;
    for (int i = NIRQ - 1; i >= 0; i--) irqid_d = (pend_q[i] & mask_q[i]) ? 5'(i) : irqid_d;
    sync1_d = EIRQ;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end
  for (genvar i = 0; i < NTMR; i++) begin : g_tmr
    localparam logic [31:0] BASE = OFF_TMR + TMR_STRIDE * 32'(i);
    assign reload_we[i] = we && off == BASE + TMR_RELOAD;
    assign ctrl_we[i]   = we && off == BASE + TMR_CTRL;
    assign reload_wd[i] = be_merge(reload_w[i], XATAI, XBE);
    assign ctrl_wd[i]   = XBE[0] ? XATAI[1:0] : {os_w[i], en_w[i]};
    io_timer_chan u_chan (
      .CLK       (CLK),
      .RESN      (RESN),
      .tick      (tick),
      .reload_we (reload_we[i]),
      .reload_wd (reload_wd[i]),
      .ctrl_we   (ctrl_we[i]),
      .ctrl_wd   (ctrl_wd[i]),
      .reload    (reload_w[i]),
      .count     (count_w[i]),
      .en        (en_w[i]),
      .oneshot   (os_w[i]),
      .pend_set  (tmr_set[i])
    );
  end
  always_ff @(posedge CLK or negedge RESN)
    if (!RESN) begin
      pend_q  <= '0;
      mask_q  <= '0;
      presc_q <= 32'(PRESC_RST);
      pcnt_q  <= 32'(PRESC_RST);
      usec_q  <= '0;
      udiv_q  <= 32'(UDIV);
      xatao_q <= '0;
      wcnt_q  <= '0;
      rack_q  <= 1'b0;
      xirq_q  <= 1'b0;
      irqid_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      usec_q  <= usec_d;
      udiv_q  <= udiv_d;
      xatao_q <= xatao_d;
      wcnt_q  <= wcnt_d;
      rack_q  <= rack_d;
      xirq_q  <= xirq_d;
      irqid_q <= irqid_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  // write acknowledge is combinational but forced low while reset is asserted
  assign XDACK = (XDREQ & XWR & RESN) | rack_q;
  assign XATAO = xatao_q;
  assign XIRQ  = xirq_q;
  assign IRQID = irqid_q;
endmodule

// File: tb/tb_io_timer_irq.sv
// tb_io_timer_irq: directed self-checking bench for io_timer_irq (NTMR=4, NEXT=8, RWAIT=2)
module tb_io_timer_irq;
  logic        CLK = 1'b0, RESN = 1'b0, XDREQ = 1'b0, XWR = 1'b0, XRD = 1'b0;
  logic [3:0]  XBE = 4'hF;
  logic [31:0] XADDR = '0, XATAI = '0;
  logic [31:0] XATAO;
  logic        XDACK, XIRQ;
  logic [7:0]  EIRQ = '0;
  logic [4:0]  IRQID;
  int checks = 0, failures = 0, cyc = 0;
  int n, lat, t1, t2;
  logic [31:0] v, v2;
  io_timer_irq #(.NTMR(4), .NEXT(8), .CLKHZ(100000000), .RWAIT(2), .AW(8)) dut (
    .CLK(CLK), .RESN(RESN), .XDREQ(XDREQ), .XWR(XWR), .XRD(XRD), .XBE(XBE),
    .XADDR(XADDR), .XATAI(XATAI), .XATAO(XATAO), .XDACK(XDACK),
    .EIRQ(EIRQ), .XIRQ(XIRQ), .IRQID(IRQID)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int k);
    repeat (k) begin @(posedge CLK); #1; end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    XDREQ = 1; XWR = 1; XADDR = a; XATAI = d; XBE = be;
    #1 chk("wr_ack", 32'(XDACK), 1);
    @(posedge CLK); #1;
    XDREQ = 0; XWR = 0; XBE = 4'hF;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d, output int l);
    XDREQ = 1; XRD = 1; XADDR = a; l = 0;
    @(posedge CLK); #1;
    while (!XDACK && l < 8) begin @(posedge CLK); #1; l++; end
    d = XATAO; XDREQ = 0; XRD = 0;
    @(posedge CLK); #1;
  endtask
  task automatic wait_irq(input int mx, output int k);
    k = 0;
    while (!XIRQ && k < mx) begin @(posedge CLK); #1; k++; end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    #1;
    chk("rst_xatao", XATAO, 0);
    chk("rst_ack_irq_id", {25'b0, XDACK, XIRQ, IRQID}, 0);
    @(posedge CLK); @(posedge CLK); #1 RESN = 1;
    rd(32'h0C, v, lat); chk("rst_presc", v, 99999); chk("rd_latency", lat, 2);
    rd(32'h00, v, lat); chk("id", v, 32'h00080464);
    rd(32'h14, v, lat); chk("unmapped_rd", v, 0);
    // periodic timer 0: (4+1)*(9+1) = 50 clocks
    wr(32'h08, 1); wr(32'h20, 4); wr(32'h0C, 9); wr(32'h28, 1);
    wait_irq(200, n); t1 = cyc;
    chk("t1_irq", 32'(XIRQ), 1); chk("t1_id", 32'(IRQID), 0);
    wr(32'h04, 1);
    chk("t1_w1c_lat", 32'(XIRQ), 1);
    cycles(1); chk("t1_w1c_clr", 32'(XIRQ), 0);
    wait_irq(100, n); t2 = cyc;
    chk("t1_period", t2 - t1, 50);
    wr(32'h04, 1); wr(32'h28, 0);
    // set wins over same-cycle W1C: PRESC=0, RELOAD=0 sets PEND[0] every clock
    wr(32'h20, 0); wr(32'h0C, 0); wr(32'h28, 1); cycles(2);
    wr(32'h04, 1); cycles(1);
    chk("t4_set_wins", 32'(XIRQ), 1);
    wr(32'h28, 0); wr(32'h04, 1); cycles(2);
    chk("t4_cleared", 32'(XIRQ), 0);
    // one-shot timer 1
    wr(32'h08, 32'hFFF); wr(32'h30, 2); wr(32'h38, 3);
    wait_irq(10, n);
    chk("t2_delay", n, 4); chk("t2_id", 32'(IRQID), 1);
    rd(32'h38, v, lat); chk("t2_ctrl", v, 2);
    rd(32'h34, v, lat); chk("t2_count", v, 2);
    rd(32'h04, v, lat); chk("t2_pend", v, 2);
    wr(32'h04, 2); cycles(10);
    chk("t2_once", 32'(XIRQ), 0);
    // external IRQ 0 rising edge, held 5 clocks
    EIRQ = 8'h01;
    wait_irq(10, n);
    chk("t3_delay", n, 4); chk("t3_id", 32'(IRQID), 4);
    cycles(1); EIRQ = 8'h00;
    rd(32'h04, v, lat); chk("t3_pend", v, 32'h10);
    wr(32'h04, 32'h10); cycles(8);
    chk("t3_once", 32'(XIRQ), 0);
    // USEC step over exactly 100 clocks, MASK byte write and width
    rd(32'h10, v, lat); chk("usec_latency", lat, 2);
    cycles(96);
    rd(32'h10, v2, lat); chk("usec_step", v2 - v, 1);
    wr(32'h08, 32'hFFFFFFFF);
    rd(32'h08, v, lat); chk("mask_width", v, 32'hFFF);
    wr(32'h08, 32'h12345600, 4'b0001);
    rd(32'h08, v, lat); chk("mask_byte", v, 32'hF00);
    // reset in the middle of a read and a running timer
    wr(32'h08, 1); wr(32'h20, 0); wr(32'h28, 1); cycles(3);
    chk("t6_irq_pre", 32'(XIRQ), 1);
    XDREQ = 1; XRD = 1; XADDR = 32'h00;
    @(posedge CLK); #1;
    chk("t6_id_latched", XATAO, 32'h80080464);
    #2 RESN = 0;
    #1;
    chk("t6_xatao", XATAO, 0);
    chk("t6_ack_irq_id", {25'b0, XDACK, XIRQ, IRQID}, 0);
    repeat (3) begin @(posedge CLK); #1; chk("t6_no_ack_rst", 32'(XDACK), 0); end
    XDREQ = 0; XRD = 0; RESN = 1;
    cycles(2); chk("t6_no_ack_post", 32'(XDACK), 0);
    rd(32'h0C, v, lat); chk("t6_presc", v, 99999);
    rd(32'h28, v, lat); chk("t6_ctrl0", v, 0);
    rd(32'h04, v, lat); chk("t6_pend", v, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
